// File: rtl/regfile_wr_sched_if.sv
// -----------------------------------------------------------------------------
// regfile_wr_sched_if
//   Bundle of every non-clock/reset signal of regfile_wr_sched.
//   Compile with REGFILE_WR_SCHED_CONFLICT_CNT_EN defined to add the conflict
//   counter signal and its CNT_W parameter.
//
//   clr_req      : single-cycle pulse that restarts the zero-clear sweep
//   init_done    : high while the scheduler is in RUN
//   a_valid/a_addr/a_data/a_ready : requester A (ALU writeback)
//   b_valid/b_addr/b_data/b_ready : requester B (load writeback)
//   A3/WD3/WE3   : registered register-file write port
//   grant        : {b,a} one-hot of the last accepted requester, registered
//   conflict_cnt : saturating count of RUN cycles with both requesters valid
//
//   master modport : the writeback side (drives requests and clr_req)
//   slave modport  : the scheduler
// -----------------------------------------------------------------------------
interface regfile_wr_sched_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
`ifdef REGFILE_WR_SCHED_CONFLICT_CNT_EN
    ,
    parameter int CNT_W  = 16
`endif
);
    logic              clr_req;
    logic              init_done;
    logic              a_valid;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_valid;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;
    logic [ADDR_W-1:0] A3;
    logic [DATA_W-1:0] WD3;
    logic              WE3;
    logic [1:0]        grant;
`ifdef REGFILE_WR_SCHED_CONFLICT_CNT_EN
    logic [CNT_W-1:0]  conflict_cnt;

    modport master (
        output clr_req, a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  init_done, a_ready, b_ready, A3, WD3, WE3, grant, conflict_cnt
    );

    modport slave (
        input  clr_req, a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output init_done, a_ready, b_ready, A3, WD3, WE3, grant, conflict_cnt
    );
`else
    modport master (
        output clr_req, a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  init_done, a_ready, b_ready, A3, WD3, WE3, grant
    );

    modport slave (
        input  clr_req, a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output init_done, a_ready, b_ready, A3, WD3, WE3, grant
    );
`endif
endinterface

// File: rtl/regfile_wr_sched.sv
// -----------------------------------------------------------------------------
// regfile_wr_sched
//   Write-port scheduler for the register file A3/WD3/WE3 port. After reset or
//   a clr_req pulse it sweeps zeros into registers 1..NREGS-1 (INIT), then
//   shares the single write port between requesters A and B with valid/ready
//   handshakes and round-robin arbitration (RUN). Writes to register 0 are
//   accepted but never enabled.
//
//   Optional feature macro: REGFILE_WR_SCHED_CONFLICT_CNT_EN
//     adds bus.conflict_cnt, a saturating count of RUN cycles in which both
//     requesters were valid (cleared by clr_req).
//
//   Ports:
//     CLK : clock, rising edge
//     rst : asynchronous active-low reset
//     bus : regfile_wr_sched_if.slave (requesters, write port, status)
// -----------------------------------------------------------------------------
module regfile_wr_sched #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int NREGS  = 2 ** ADDR_W
`ifdef REGFILE_WR_SCHED_CONFLICT_CNT_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic                 CLK,
    input  logic                 rst,
    regfile_wr_sched_if.slave    bus
);
    typedef enum logic {S_INIT, S_RUN} state_e;

    localparam logic [ADDR_W-1:0] LAST_REG  = ADDR_W'(NREGS - 1);
    localparam logic [ADDR_W-1:0] FIRST_REG = ADDR_W'(1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] sweep_ptr_q, sweep_ptr_d;
    logic [ADDR_W-1:0] a3_q, a3_d;
    logic [DATA_W-1:0] wd3_q, wd3_d;
    logic              we3_q, we3_d;
    logic [1:0]        grant_q, grant_d;
    logic              rr_prio_q, rr_prio_d;   // 0: A holds priority, 1: B

    logic run, both_valid, a_win, b_win;

    // Readiness is purely combinational so a requester sees its accept in the
    // same cycle; clr_req masks both so nothing is lost across a restart.
    always_comb begin
        run        = (state_q == S_RUN);
        both_valid = bus.a_valid & bus.b_valid;
        a_win      = run & ~bus.clr_req & bus.a_valid & (~bus.b_valid | ~rr_prio_q);
        b_win      = run & ~bus.clr_req & bus.b_valid & (~bus.a_valid |  rr_prio_q);
    end

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        sweep_ptr_d = sweep_ptr_q;
        a3_d        = a3_q;
        wd3_d       = wd3_q;
        we3_d       = 1'b0;
        grant_d     = 2'b00;
        rr_prio_d   = rr_prio_q;

        case (state_q)
            S_INIT: begin
                if (bus.clr_req) begin
                    sweep_ptr_d = FIRST_REG;
                end else begin
                    a3_d  = sweep_ptr_q;
                    wd3_d = '0;
                    we3_d = 1'b1;
                    if (sweep_ptr_q == LAST_REG) begin
                        state_d     = S_RUN;
                        sweep_ptr_d = FIRST_REG;
                    end else begin
                        sweep_ptr_d = sweep_ptr_q + 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (bus.clr_req) begin
                    state_d     = S_INIT;
                    sweep_ptr_d = FIRST_REG;
                end else if (a_win) begin
                    a3_d    = bus.a_addr;
                    wd3_d   = bus.a_data;
                    we3_d   = (bus.a_addr != '0);
                    grant_d = 2'b01;
                    if (both_valid) rr_prio_d = 1'b1;
                end else if (b_win) begin
                    a3_d    = bus.b_addr;
                    wd3_d   = bus.b_data;
                    we3_d   = (bus.b_addr != '0);
                    grant_d = 2'b10;
                    if (both_valid) rr_prio_d = 1'b0;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state_q     <= S_INIT;
            sweep_ptr_q <= FIRST_REG;
            a3_q        <= '0;
            wd3_q       <= '0;
            we3_q       <= 1'b0;
            grant_q     <= 2'b00;
            rr_prio_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sweep_ptr_q <= sweep_ptr_d;
            a3_q        <= a3_d;
            wd3_q       <= wd3_d;
            we3_q       <= we3_d;
            grant_q     <= grant_d;
            rr_prio_q   <= rr_prio_d;
        end
    end

    assign bus.init_done = run;
    assign bus.a_ready   = a_win;
    assign bus.b_ready   = b_win;
    assign bus.A3        = a3_q;
    assign bus.WD3       = wd3_q;
    assign bus.WE3       = we3_q;
    assign bus.grant     = grant_q;

`ifdef REGFILE_WR_SCHED_CONFLICT_CNT_EN
    logic [CNT_W-1:0] conflict_cnt_q;

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            conflict_cnt_q <= '0;
        end else if (bus.clr_req) begin
            conflict_cnt_q <= '0;
        end else if (run && both_valid && (conflict_cnt_q != '1)) begin
            conflict_cnt_q <= conflict_cnt_q + 1'b1;
        end
    end

    assign bus.conflict_cnt = conflict_cnt_q;
`endif
endmodule

// File: tb/tb_regfile_wr_sched.sv
// -----------------------------------------------------------------------------
// tb_regfile_wr_sched
//   Directed bench for regfile_wr_sched. Inputs change 1 time unit after a
//   rising edge; registered outputs are sampled there, combinational readies
//   on the falling edge.
// -----------------------------------------------------------------------------
module tb_regfile_wr_sched;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic CLK = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 CLK = ~CLK;

    regfile_wr_sched_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    regfile_wr_sched #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .NREGS (32)
    ) dut (
        .CLK(CLK),
        .rst(rst),
        .bus(bus)
    );

    task automatic idle_inputs();
        bus.clr_req = 1'b0;
        bus.a_valid = 1'b0;
        bus.a_addr  = '0;
        bus.a_data  = '0;
        bus.b_valid = 1'b0;
        bus.b_addr  = '0;
        bus.b_data  = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        bus.a_valid = 1'b1;
        bus.b_valid = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if ({bus.WE3, bus.init_done, bus.a_ready, bus.b_ready, bus.grant} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=000000",
                     {bus.WE3, bus.init_done, bus.a_ready, bus.b_ready, bus.grant});
        end
        checks++;
        if ({bus.A3, bus.WD3} !== 37'h0) begin
            failures++;
            $display("FAIL reset_data got A3=%h WD3=%h exp 0/0", bus.A3, bus.WD3);
        end
        idle_inputs();
        @(negedge CLK);
        rst = 1'b1;
    endtask

    task automatic test_sweep();
        for (int i = 1; i <= 31; i++) begin
            @(posedge CLK);
            #1;
            checks++;
            if ({bus.WE3, bus.A3, bus.WD3} !== {1'b1, 5'(i), 32'h0}) begin
                failures++;
                $display("FAIL sweep_write[%0d] got WE3=%b A3=%0d WD3=%h exp 1/%0d/0",
                         i, bus.WE3, bus.A3, bus.WD3, i);
            end
            checks++;
            if (bus.init_done !== (i == 31)) begin
                failures++;
                $display("FAIL sweep_init_done[%0d] got=%b exp=%b", i, bus.init_done, (i == 31));
            end
        end
        @(posedge CLK);
        #1;
        checks++;
        if ({bus.WE3, bus.grant, bus.init_done} !== 4'b0001) begin
            failures++;
            $display("FAIL sweep_end got WE3/grant/init_done=%b exp=0001",
                     {bus.WE3, bus.grant, bus.init_done});
        end
    endtask

    task automatic test_single_write();
        bus.a_valid = 1'b1;
        bus.a_addr  = 5'd5;
        bus.a_data  = 32'hDEAD_BEEF;
        @(negedge CLK);
        checks++;
        if ({bus.a_ready, bus.b_ready} !== 2'b10) begin
            failures++;
            $display("FAIL single_ready got a/b=%b exp=10", {bus.a_ready, bus.b_ready});
        end
        @(posedge CLK);
        #1;
        bus.a_valid = 1'b0;
        checks++;
        if ({bus.WE3, bus.grant, bus.A3, bus.WD3} !== {1'b1, 2'b01, 5'd5, 32'hDEAD_BEEF}) begin
            failures++;
            $display("FAIL single_write got WE3=%b grant=%b A3=%0d WD3=%h exp 1/01/5/deadbeef",
                     bus.WE3, bus.grant, bus.A3, bus.WD3);
        end
        @(posedge CLK);
        #1;
        checks++;
        if ({bus.WE3, bus.grant, bus.A3, bus.WD3} !== {1'b0, 2'b00, 5'd5, 32'hDEAD_BEEF}) begin
            failures++;
            $display("FAIL single_idle got WE3=%b grant=%b A3=%0d WD3=%h exp 0/00/5/deadbeef",
                     bus.WE3, bus.grant, bus.A3, bus.WD3);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  a_list [2] = '{5'd3, 5'd4};
        logic [4:0]  b_list [2] = '{5'd7, 5'd8};
        logic [4:0]  exp_addr [4] = '{5'd3, 5'd7, 5'd4, 5'd8};
        logic [3:0]  exp_b = 4'b1010;   // bit k set: B wins cycle k
        int ai = 0;
        int bi = 0;
        bus.a_valid = 1'b1; bus.a_addr = a_list[0]; bus.a_data = {27'h0A00000, a_list[0]};
        bus.b_valid = 1'b1; bus.b_addr = b_list[0]; bus.b_data = {27'h0B00000, b_list[0]};
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            checks++;
            if ({bus.a_ready, bus.b_ready} !== {~exp_b[k], exp_b[k]}) begin
                failures++;
                $display("FAIL b2b_ready[%0d] got a/b=%b exp=%b",
                         k, {bus.a_ready, bus.b_ready}, {~exp_b[k], exp_b[k]});
            end
            @(posedge CLK);
            #1;
            checks++;
            if ({bus.WE3, bus.grant, bus.A3, bus.WD3} !==
                {1'b1, (exp_b[k] ? 2'b10 : 2'b01), exp_addr[k],
                 (exp_b[k] ? 27'h0B00000 : 27'h0A00000), exp_addr[k]}) begin
                failures++;
                $display("FAIL b2b_write[%0d] got WE3=%b grant=%b A3=%0d WD3=%h exp_addr=%0d",
                         k, bus.WE3, bus.grant, bus.A3, bus.WD3, exp_addr[k]);
            end
            if (exp_b[k]) begin
                bi++;
                bus.b_valid = (bi < 2);
                if (bi < 2) begin
                    bus.b_addr = b_list[bi];
                    bus.b_data = {27'h0B00000, b_list[bi]};
                end
            end else begin
                ai++;
                bus.a_valid = (ai < 2);
                if (ai < 2) begin
                    bus.a_addr = a_list[ai];
                    bus.a_data = {27'h0A00000, a_list[ai]};
                end
            end
        end
        @(posedge CLK);
        #1;
        checks++;
        if ({bus.WE3, bus.grant} !== 3'b000) begin
            failures++;
            $display("FAIL b2b_idle got WE3/grant=%b exp=000", {bus.WE3, bus.grant});
        end
`ifdef REGFILE_WR_SCHED_CONFLICT_CNT_EN
        checks++;
        if (bus.conflict_cnt !== 16'd3) begin
            failures++;
            $display("FAIL b2b_conflict_cnt got=%0d exp=3", bus.conflict_cnt);
        end
`endif
    endtask

    // Last contested cycle went to A and the following single B grant left
    // priority with B, so B must win the next contest.
    task automatic test_rr_hold();
        bus.a_valid = 1'b1; bus.a_addr = 5'd10; bus.a_data = 32'h0000_0010;
        bus.b_valid = 1'b1; bus.b_addr = 5'd11; bus.b_data = 32'h0000_0011;
        @(negedge CLK);
        checks++;
        if ({bus.a_ready, bus.b_ready} !== 2'b01) begin
            failures++;
            $display("FAIL rr_hold_ready got a/b=%b exp=01", {bus.a_ready, bus.b_ready});
        end
        @(posedge CLK);
        #1;
        bus.b_valid = 1'b0;
        checks++;
        if ({bus.grant, bus.A3} !== {2'b10, 5'd11}) begin
            failures++;
            $display("FAIL rr_hold_b got grant=%b A3=%0d exp 10/11", bus.grant, bus.A3);
        end
        @(negedge CLK);
        checks++;
        if (bus.a_ready !== 1'b1) begin
            failures++;
            $display("FAIL rr_hold_a_ready got=%b exp=1", bus.a_ready);
        end
        @(posedge CLK);
        #1;
        bus.a_valid = 1'b0;
        checks++;
        if ({bus.WE3, bus.grant, bus.A3, bus.WD3} !== {1'b1, 2'b01, 5'd10, 32'h0000_0010}) begin
            failures++;
            $display("FAIL rr_hold_a got WE3=%b grant=%b A3=%0d WD3=%h exp 1/01/10/10",
                     bus.WE3, bus.grant, bus.A3, bus.WD3);
        end
`ifdef REGFILE_WR_SCHED_CONFLICT_CNT_EN
        checks++;
        if (bus.conflict_cnt !== 16'd4) begin
            failures++;
            $display("FAIL rr_hold_conflict_cnt got=%0d exp=4", bus.conflict_cnt);
        end
`endif
    endtask

    task automatic test_addr_zero();
        bus.b_valid = 1'b1; bus.b_addr = 5'd0; bus.b_data = 32'h0000_1234;
        @(negedge CLK);
        checks++;
        if (bus.b_ready !== 1'b1) begin
            failures++;
            $display("FAIL zero_ready got=%b exp=1", bus.b_ready);
        end
        @(posedge CLK);
        #1;
        bus.b_valid = 1'b0;
        checks++;
        if ({bus.WE3, bus.grant} !== 3'b010) begin
            failures++;
            $display("FAIL zero_write got WE3/grant=%b exp=010", {bus.WE3, bus.grant});
        end
    endtask

    task automatic test_clear();
        bus.a_valid = 1'b1; bus.a_addr = 5'd9; bus.a_data = 32'h0000_0099;
        bus.clr_req = 1'b1;
        @(negedge CLK);
        checks++;
        if (bus.a_ready !== 1'b0) begin
            failures++;
            $display("FAIL clr_ready got=%b exp=0", bus.a_ready);
        end
        @(posedge CLK);
        #1;
        bus.clr_req = 1'b0;
        checks++;
        if ({bus.WE3, bus.init_done} !== 2'b00) begin
            failures++;
            $display("FAIL clr_edge got WE3/init_done=%b exp=00", {bus.WE3, bus.init_done});
        end
`ifdef REGFILE_WR_SCHED_CONFLICT_CNT_EN
        checks++;
        if (bus.conflict_cnt !== 16'd0) begin
            failures++;
            $display("FAIL clr_conflict_cnt got=%0d exp=0", bus.conflict_cnt);
        end
`endif
        for (int i = 1; i <= 31; i++) begin
            @(negedge CLK);
            checks++;
            if (bus.a_ready !== 1'b0) begin
                failures++;
                $display("FAIL clr_sweep_ready[%0d] got=%b exp=0", i, bus.a_ready);
            end
            @(posedge CLK);
            #1;
            checks++;
            if ({bus.WE3, bus.A3, bus.WD3, bus.init_done} !== {1'b1, 5'(i), 32'h0, (i == 31)}) begin
                failures++;
                $display("FAIL clr_sweep[%0d] got WE3=%b A3=%0d WD3=%h init_done=%b",
                         i, bus.WE3, bus.A3, bus.WD3, bus.init_done);
            end
        end
        @(negedge CLK);
        checks++;
        if (bus.a_ready !== 1'b1) begin
            failures++;
            $display("FAIL clr_after_ready got=%b exp=1", bus.a_ready);
        end
        @(posedge CLK);
        #1;
        bus.a_valid = 1'b0;
        checks++;
        if ({bus.WE3, bus.grant, bus.A3, bus.WD3} !== {1'b1, 2'b01, 5'd9, 32'h0000_0099}) begin
            failures++;
            $display("FAIL clr_after_write got WE3=%b grant=%b A3=%0d WD3=%h exp 1/01/9/99",
                     bus.WE3, bus.grant, bus.A3, bus.WD3);
        end
    endtask

    task automatic test_reset_mid_sweep();
        bus.clr_req = 1'b1;
        @(posedge CLK);
        #1;
        bus.clr_req = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge CLK);
            #1;
            checks++;
            if ({bus.WE3, bus.A3} !== {1'b1, 5'(i)}) begin
                failures++;
                $display("FAIL mid_sweep[%0d] got WE3=%b A3=%0d", i, bus.WE3, bus.A3);
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.WE3, bus.A3, bus.WD3, bus.grant, bus.init_done} !== 41'h0) begin
            failures++;
            $display("FAIL mid_reset got WE3=%b A3=%0d WD3=%h grant=%b init_done=%b",
                     bus.WE3, bus.A3, bus.WD3, bus.grant, bus.init_done);
        end
        @(posedge CLK);
        #1;
        checks++;
        if ({bus.WE3, bus.A3} !== 6'h0) begin
            failures++;
            $display("FAIL mid_reset_hold got WE3=%b A3=%0d exp 0/0", bus.WE3, bus.A3);
        end
        @(negedge CLK);
        rst = 1'b1;
        @(posedge CLK);
        #1;
        checks++;
        if ({bus.WE3, bus.A3, bus.init_done} !== {1'b1, 5'd1, 1'b0}) begin
            failures++;
            $display("FAIL restart_sweep got WE3=%b A3=%0d init_done=%b exp 1/1/0",
                     bus.WE3, bus.A3, bus.init_done);
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_single_write();
        test_back_to_back();
        test_rr_hold();
        test_addr_zero();
        test_clear();
        test_reset_mid_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/regfile_wr_sched.md
Name: regfile_wr_sched

Overview:
Write-port scheduler for the 32x32 register file (A3/WD3/WE3 port).
- After reset, or on request, sequences a zero-clear sweep of registers 1..NREGS-1.
- Then shares the single write port between two writeback requesters, A (ALU) and B (load), using valid/ready handshakes and round-robin arbitration.
- Sits between the writeback stages and the register file write port.

Parameters:
ADDR_W, 5, register address width
DATA_W, 32, register data width
NREGS, 32, number of registers, 2**ADDR_W; register 0 is never written
CNT_W, 16, conflict counter width (optional feature only)

Ports:
CLK  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
clr_req  input  1  single-cycle pulse: restart the clear sweep
init_done  output  1  high while in RUN
a_valid  input  1  requester A has a write
a_addr  input  ADDR_W  requester A destination
a_data  input  DATA_W  requester A data
a_ready  output  1  A accepted this cycle
b_valid  input  1  requester B has a write
b_addr  input  ADDR_W  requester B destination
b_data  input  DATA_W  requester B data
b_ready  output  1  B accepted this cycle
A3  output  ADDR_W  register file write address, registered
WD3  output  DATA_W  register file write data, registered
WE3  output  1  register file write enable, registered
grant  output  2  {b,a} one-hot of last accepted requester, registered

Behaviour:
- Reset (rst=0, async): state=INIT, sweep_ptr=1, rr_prio=A, A3=0, WD3=0, WE3=0, grant=00, init_done=0, a_ready=b_ready=0.
- INIT: each edge registers A3=sweep_ptr, WD3=0, WE3=1, then increments sweep_ptr.
  - On the edge that registers sweep_ptr=NREGS-1: state becomes RUN, init_done=1.
  - Sweep = NREGS-1 consecutive writes (31 by default); register 0 is skipped.
  - a_ready and b_ready stay 0 throughout INIT.
- RUN, readiness:
  - a_ready/b_ready are combinational from valids, rr_prio and clr_req.
  - Both are 0 in any cycle where clr_req=1.
- RUN, arbitration:
  - Only A valid: A wins. Only B valid: B wins.
  - Both valid: the rr_prio holder wins, and rr_prio moves to the loser at the edge.
  - Single-requester grants leave rr_prio unchanged.
- Accept latency: exactly 1 cycle. The edge after accept registers A3=addr, WD3=data, WE3=1 and sets grant to the winner.
- No accept in a cycle: WE3=0 at the next edge, grant=00; A3/WD3 hold their values.
- Write to address 0: the handshake completes (ready=1) but WE3=0; grant still updates.
- clr_req in RUN: next edge goes to INIT with sweep_ptr=1 and init_done=0; WE3=0 on that edge.
- clr_req in INIT: sweep_ptr reloads to 1 (the sweep restarts).
- Reset mid-sweep or mid-transfer: immediate return to reset values; a pending request is simply re-presented by its requester.
- Requesters hold valid/addr/data stable until ready; the block never stores more than the one registered write.

Optional Feature:
REGFILE_WR_SCHED_CONFLICT_CNT_EN
- Defined:
  - Adds output conflict_cnt [CNT_W-1:0], reset 0.
  - Increments each RUN cycle with a_valid=b_valid=1 and clr_req=0.
  - Saturates at all-ones; cleared by clr_req.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
1. Release rst, no requests -> WE3=1 for 31 consecutive cycles with A3=1..31 and WD3=0; init_done=1 on the edge registering A3=31; then WE3=0.
2. RUN, a_valid=1 with a_addr=5, a_data=0xDEADBEEF, for one cycle -> a_ready=1 that cycle; next edge A3=5, WD3=0xDEADBEEF, WE3=1, grant=01.
3. RUN, A and B both valid for 4 cycles (A addr 3/4, B addr 7/8) -> grants alternate A,B,A,B; each held request is accepted exactly once; WE3=1 for 4 consecutive cycles.
4. b_valid=1 with b_addr=0, b_data=0x1234 -> b_ready=1; next edge WE3=0, grant=10.
5. Assert clr_req while A is valid -> a_ready=0 that cycle; sweep restarts (A3=1..31); A is accepted only after init_done returns to 1. With REGFILE_WR_SCHED_CONFLICT_CNT_EN defined, conflict_cnt=0 after clr_req.
6. Drop rst at sweep write A3=12 -> outputs go to reset values immediately; after release the sweep restarts at A3=1.
